// File: rtl/p_addsub_pipe.sv
// Two-stage pipelined packed add/subtract with valid/ready handshake; carry chain split at XLEN/2.
// Optional per-lane carry/borrow output port out_flags is enabled by defining P_ADDSUB_PIPE_FLAGS_EN.
module p_addsub_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PWW  = $clog2(XLEN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   lhs,
  input  logic [XLEN-1:0]   rhs,
  input  logic [PWW-1:0]    pw,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
`ifdef P_ADDSUB_PIPE_FLAGS_EN
  output logic [XLEN/2-1:0] out_flags,
`endif
  output logic              pw_err
);

  localparam int unsigned Half = XLEN / 2;

  // Lane-start mask for bits [base +: Half]: a bit starts a lane when its index is a
  // multiple of the selected lane width.
  function automatic logic [Half-1:0] lane_starts(input logic [PWW-1:0] sel,
                                                  input int unsigned    base);
    logic [Half-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < PWW; i++) begin
      if (sel[i]) begin
        for (int unsigned b = 0; b < Half; b++) begin
          if (((b + base) & ((XLEN >> i) - 1)) == 0) m[b] = 1'b1;
        end
      end
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_adv, accept;

  always_comb begin
    s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
    in_ready = ~s1_valid_q | s2_adv;
    accept   = in_valid & in_ready;

    s1_valid_d = s1_valid_q;
    if (accept)      s1_valid_d = 1'b1;
    else if (s2_adv) s1_valid_d = 1'b0;

    s2_valid_d = s2_valid_q;
    if (s2_adv)         s2_valid_d = 1'b1;
    else if (out_ready) s2_valid_d = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: lower-half lanes and mid-carry
  // ---------------------------------------------------------------------------
  int unsigned     pw_ones;
  logic            in_err;
  logic [Half-1:0] lo_start;
  logic [Half-1:0] lo_sum;
  logic            lo_carry;
  logic            lo_cin;
  logic            lo_rb;
`ifdef P_ADDSUB_PIPE_FLAGS_EN
  logic [Half-1:0] lo_cout;
`endif

  always_comb begin
    pw_ones = 0;
    for (int unsigned i = 0; i < PWW; i++) begin
      if (pw[i]) pw_ones++;
    end
    in_err   = (pw_ones != 1);
    lo_start = lane_starts(pw, 0);
    lo_carry = 1'b0;
    lo_cin   = 1'b0;
    lo_rb    = 1'b0;
    lo_sum   = '0;
`ifdef P_ADDSUB_PIPE_FLAGS_EN
    lo_cout  = '0;
`endif
    for (int unsigned b = 0; b < Half; b++) begin
      lo_rb     = rhs[b] ^ sub;
      lo_cin    = lo_start[b] ? sub : lo_carry;
      lo_sum[b] = lhs[b] ^ lo_rb ^ lo_cin;
      lo_carry  = (lhs[b] & lo_rb) | (lo_cin & (lhs[b] ^ lo_rb));
`ifdef P_ADDSUB_PIPE_FLAGS_EN
      lo_cout[b] = lo_carry;
`endif
    end
  end

  logic [Half-1:0] s1_lhs_hi_q, s1_lhs_hi_d;
  logic [Half-1:0] s1_rhs_hi_q, s1_rhs_hi_d;
  logic [PWW-1:0]  s1_pw_q, s1_pw_d;
  logic            s1_sub_q, s1_sub_d;
  logic            s1_err_q, s1_err_d;
  logic [Half-1:0] s1_lo_sum_q, s1_lo_sum_d;
  logic            s1_mid_carry_q, s1_mid_carry_d;
`ifdef P_ADDSUB_PIPE_FLAGS_EN
  logic [Half-1:0] s1_lo_cout_q, s1_lo_cout_d;
`endif

  always_comb begin
    s1_lhs_hi_d    = s1_lhs_hi_q;
    s1_rhs_hi_d    = s1_rhs_hi_q;
    s1_pw_d        = s1_pw_q;
    s1_sub_d       = s1_sub_q;
    s1_err_d       = s1_err_q;
    s1_lo_sum_d    = s1_lo_sum_q;
    s1_mid_carry_d = s1_mid_carry_q;
`ifdef P_ADDSUB_PIPE_FLAGS_EN
    s1_lo_cout_d   = s1_lo_cout_q;
`endif
    if (accept) begin
      s1_lhs_hi_d    = lhs[XLEN-1:Half];
      s1_rhs_hi_d    = rhs[XLEN-1:Half];
      s1_pw_d        = pw;
      s1_sub_d       = sub;
      s1_err_d       = in_err;
      s1_lo_sum_d    = lo_sum;
      s1_mid_carry_d = lo_carry;
`ifdef P_ADDSUB_PIPE_FLAGS_EN
      s1_lo_cout_d   = lo_cout;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: upper-half lanes; the mid-carry only matters for full-width lanes,
  // since bit Half is a lane start for every narrower width.
  // ---------------------------------------------------------------------------
  logic [Half-1:0] hi_start;
  logic [Half-1:0] hi_sum;
  logic            hi_carry;
  logic            hi_cin;
  logic            hi_rb;
`ifdef P_ADDSUB_PIPE_FLAGS_EN
  logic [Half-1:0] hi_cout;
  logic [XLEN-1:0] all_cout;
  logic [Half-1:0] flags_calc;
`endif

  always_comb begin
    hi_start = lane_starts(s1_pw_q, Half);
    hi_carry = s1_mid_carry_q;
    hi_cin   = 1'b0;
    hi_rb    = 1'b0;
    hi_sum   = '0;
`ifdef P_ADDSUB_PIPE_FLAGS_EN
    hi_cout  = '0;
`endif
    for (int unsigned b = 0; b < Half; b++) begin
      hi_rb     = s1_rhs_hi_q[b] ^ s1_sub_q;
      hi_cin    = hi_start[b] ? s1_sub_q : hi_carry;
      hi_sum[b] = s1_lhs_hi_q[b] ^ hi_rb ^ hi_cin;
      hi_carry  = (s1_lhs_hi_q[b] & hi_rb) | (hi_cin & (s1_lhs_hi_q[b] ^ hi_rb));
`ifdef P_ADDSUB_PIPE_FLAGS_EN
      hi_cout[b] = hi_carry;
`endif
    end
  end

`ifdef P_ADDSUB_PIPE_FLAGS_EN
  // Flag j is the carry out of lane j's MSB, inverted into a borrow for subtract.
  always_comb begin
    all_cout   = {hi_cout, s1_lo_cout_q};
    flags_calc = '0;
    for (int unsigned i = 0; i < PWW; i++) begin
      if (s1_pw_q[i]) begin
        for (int unsigned j = 0; j < Half; j++) begin
          if (j < (32'd1 << i)) begin
            flags_calc[j] = all_cout[((j + 1) * (XLEN >> i)) - 1] ^ s1_sub_q;
          end
        end
      end
    end
  end
`endif

  logic [XLEN-1:0] s2_result_q, s2_result_d;
  logic            s2_err_q, s2_err_d;
`ifdef P_ADDSUB_PIPE_FLAGS_EN
  logic [Half-1:0] s2_flags_q, s2_flags_d;
`endif

  always_comb begin
    s2_result_d = s2_result_q;
    s2_err_d    = s2_err_q;
`ifdef P_ADDSUB_PIPE_FLAGS_EN
    s2_flags_d  = s2_flags_q;
`endif
    if (s2_adv) begin
      s2_result_d = s1_err_q ? '0 : {hi_sum, s1_lo_sum_q};
      s2_err_d    = s1_err_q;
`ifdef P_ADDSUB_PIPE_FLAGS_EN
      s2_flags_d  = s1_err_q ? '0 : flags_calc;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q     <= 1'b0;
      s2_valid_q     <= 1'b0;
      s1_lhs_hi_q    <= '0;
      s1_rhs_hi_q    <= '0;
      s1_pw_q        <= '0;
      s1_sub_q       <= 1'b0;
      s1_err_q       <= 1'b0;
      s1_lo_sum_q    <= '0;
      s1_mid_carry_q <= 1'b0;
      s2_result_q    <= '0;
      s2_err_q       <= 1'b0;
`ifdef P_ADDSUB_PIPE_FLAGS_EN
      s1_lo_cout_q   <= '0;
      s2_flags_q     <= '0;
`endif
    end else begin
      s1_valid_q     <= s1_valid_d;
      s2_valid_q     <= s2_valid_d;
      s1_lhs_hi_q    <= s1_lhs_hi_d;
      s1_rhs_hi_q    <= s1_rhs_hi_d;
      s1_pw_q        <= s1_pw_d;
      s1_sub_q       <= s1_sub_d;
      s1_err_q       <= s1_err_d;
      s1_lo_sum_q    <= s1_lo_sum_d;
      s1_mid_carry_q <= s1_mid_carry_d;
      s2_result_q    <= s2_result_d;
      s2_err_q       <= s2_err_d;
`ifdef P_ADDSUB_PIPE_FLAGS_EN
      s1_lo_cout_q   <= s1_lo_cout_d;
      s2_flags_q     <= s2_flags_d;
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = s2_result_q;
  assign pw_err    = s2_err_q;
`ifdef P_ADDSUB_PIPE_FLAGS_EN
  assign out_flags = s2_flags_q;
`endif

endmodule

// File: tb/tb_p_addsub_pipe.sv
// Directed self-checking bench for p_addsub_pipe at XLEN=32 and XLEN=64.
module tb_p_addsub_pipe;

  logic        clock;
  logic        reset;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [4:0]  pw;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        pw_err;
`ifdef P_ADDSUB_PIPE_FLAGS_EN
  logic [15:0] flags;
`endif

  logic        w_in_valid;
  logic        w_in_ready;
  logic [63:0] w_lhs;
  logic [63:0] w_rhs;
  logic [5:0]  w_pw;
  logic        w_sub;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [63:0] w_result;
  logic        w_pw_err;
`ifdef P_ADDSUB_PIPE_FLAGS_EN
  logic [31:0] w_flags;
`endif

  int unsigned n_vec;
  int unsigned n_err;

  p_addsub_pipe #(.XLEN(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lhs       (lhs),
    .rhs       (rhs),
    .pw        (pw),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
`ifdef P_ADDSUB_PIPE_FLAGS_EN
    .out_flags (flags),
`endif
    .pw_err    (pw_err)
  );

  p_addsub_pipe #(.XLEN(64)) dut64 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .lhs       (w_lhs),
    .rhs       (w_rhs),
    .pw        (w_pw),
    .sub       (w_sub),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .result    (w_result),
`ifdef P_ADDSUB_PIPE_FLAGS_EN
    .out_flags (w_flags),
`endif
    .pw_err    (w_pw_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one operand set and hold it until accepted (bounded); returns #1 after the accept edge.
  task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] p, input logic s);
    int unsigned t;
    lhs = a; rhs = b; pw = p; sub = s; in_valid = 1'b1;
    #1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(posedge clock); #1;
      t++;
    end
    check_eq({tag, "_in_ready"}, in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] p, input logic s, input logic [31:0] exp_res,
                        input logic exp_err, input logic [15:0] exp_flags);
    send(tag, a, b, p, s);
    check_eq({tag, "_lat0"}, out_valid, 0);
    @(posedge clock); #1;
    check_eq({tag, "_valid"}, out_valid, 1);
    check_eq({tag, "_result"}, result, exp_res);
    check_eq({tag, "_err"}, pw_err, exp_err);
`ifdef P_ADDSUB_PIPE_FLAGS_EN
    check_eq({tag, "_flags"}, flags, exp_flags);
`else
    if (exp_flags === 16'hxxxx) $display("note: %s flags undefined", tag);
`endif
  endtask

  task automatic run_op64(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [5:0] p, input logic [63:0] exp_res);
    int unsigned t;
    w_lhs = a; w_rhs = b; w_pw = p; w_sub = 1'b0; w_in_valid = 1'b1;
    #1;
    t = 0;
    while (!w_in_ready && t < 20) begin
      @(posedge clock); #1;
      t++;
    end
    check_eq({tag, "_in_ready"}, w_in_ready, 1);
    @(posedge clock); #1;
    w_in_valid = 1'b0;
    check_eq({tag, "_lat0"}, w_out_valid, 0);
    @(posedge clock); #1;
    check_eq({tag, "_valid"}, w_out_valid, 1);
    check_eq({tag, "_result"}, w_result, exp_res);
    check_eq({tag, "_err"}, w_pw_err, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    in_valid = 1'b0; lhs = '0; rhs = '0; pw = 5'b00001; sub = 1'b0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_lhs = '0; w_rhs = '0; w_pw = 6'b000001; w_sub = 1'b0;
    w_out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_pw_err", pw_err, 0);

    // Single ops with out_ready high
    run_op("add32_mid",  32'h0000FFFF, 32'h00000001, 5'b00001, 1'b0, 32'h00010000, 1'b0, 16'h0000);
    run_op("sub8",       32'h00000000, 32'h01010101, 5'b00100, 1'b1, 32'hFFFFFFFF, 1'b0, 16'h000F);
    run_op("add2_wrap",  32'hFFFFFFFF, 32'h55555555, 5'b10000, 1'b0, 32'h00000000, 1'b0, 16'hFFFF);
    run_op("add16_iso",  32'hFFFF0001, 32'h00010001, 5'b00010, 1'b0, 32'h00000002, 1'b0, 16'h0002);
    run_op("sub4",       32'h12345678, 32'h11111111, 5'b01000, 1'b1, 32'h01234567, 1'b0, 16'h0000);
    run_op("sub32_mid",  32'h00010000, 32'h00000001, 5'b00001, 1'b1, 32'h0000FFFF, 1'b0, 16'h0000);
    run_op("bad_pw2",    32'h12345678, 32'h00000001, 5'b00011, 1'b0, 32'h00000000, 1'b1, 16'h0000);
    run_op("good_after", 32'h12345678, 32'h00000001, 5'b00001, 1'b0, 32'h12345679, 1'b0, 16'h0000);
    run_op("bad_pw0",    32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00000, 1'b1, 32'h00000000, 1'b1, 16'h0000);

    // Back-to-back with output stall
    @(posedge clock); #1;
    out_ready = 1'b0;
    send("stall_op1", 32'h1, 32'h2, 5'b00001, 1'b0);
    send("stall_op2", 32'h3, 32'h4, 5'b00001, 1'b0);
    check_eq("stall_full_in_ready", in_ready, 0);
    check_eq("stall_out_valid", out_valid, 1);
    lhs = 32'h5; rhs = 32'h6; pw = 5'b00001; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check_eq("stall_hold_in_ready", in_ready, 0);
      check_eq("stall_hold_result", result, 32'h3);
      check_eq("stall_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    check_eq("release_in_ready", in_ready, 1);
    check_eq("release_result0", result, 32'h3);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check_eq("order_r1_valid", out_valid, 1);
    check_eq("order_r1", result, 32'h7);
    @(posedge clock); #1;
    check_eq("order_r2_valid", out_valid, 1);
    check_eq("order_r2", result, 32'hB);
    @(posedge clock); #1;
    check_eq("order_drained", out_valid, 0);

    // Reset with two ops in flight
    out_ready = 1'b0;
    send("rst_op1", 32'h10, 32'h20, 5'b00001, 1'b0);
    send("rst_op2", 32'h30, 32'h40, 5'b00001, 1'b0);
    check_eq("rst_pre_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    check_eq("rst_async_valid", out_valid, 0);
    check_eq("rst_async_result", result, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    check_eq("rst_post_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check_eq("rst_no_stale", out_valid, 0);
    end
    run_op("post_rst", 32'h00000100, 32'h00000023, 5'b00001, 1'b0, 32'h00000123, 1'b0, 16'h0000);

    // 64-bit instance
    run_op64("add64_mid", 64'h00000000FFFFFFFF, 64'h1, 6'b000001, 64'h0000000100000000);
    run_op64("add64_l32", 64'hFFFFFFFFFFFFFFFF, 64'h1, 6'b000010, 64'hFFFFFFFF00000000);

    @(posedge clock); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/p_addsub_pipe.md
Name: p_addsub_pipe

Overview:
- Parametrised, two-stage pipelined packed add/subtract unit with a valid/ready handshake on input and output.
- Generalises the combinational packed adder to XLEN of 32 or 64. Pack widths run from XLEN down to 2 bits.
- The carry chain is split at bit XLEN/2. The registered mid-carry lets the unit close timing at wide XLEN.
- Sits in the crypto ALU datapath between operand issue and writeback arbitration.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- PWW, $clog2(XLEN), width of the one-hot pack-width select (5 for XLEN=32, 6 for XLEN=64).

Ports:
- clock, input, 1, sole clock; rising edge.
- reset, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, operands valid.
- in_ready, output, 1, unit can accept operands this cycle.
- lhs, input, XLEN, left-hand operand.
- rhs, input, XLEN, right-hand operand.
- pw, input, PWW, one-hot pack width: pw[i] selects lanes of XLEN>>i bits (pw[0]=XLEN, pw[PWW-1]=2).
- sub, input, 1, 1 = lhs-rhs per lane, 0 = lhs+rhs per lane.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- result, output, XLEN, packed result, each lane modulo 2^lanewidth.
- pw_err, output, 1, qualifies result: pw was not one-hot.

Behaviour:
- Reset (async assert, sync-safe deassert): s1_valid=0, s2_valid=0. Outputs: out_valid=0, result=0, pw_err=0. in_ready goes 1 in the first cycle after reset deasserts.
- Acceptance: a transfer occurs on a rising edge with in_valid&in_ready. Output transfer occurs on out_valid&out_ready.
- Stage 1, captured at acceptance:
  - Registers lhs/rhs upper halves, pw, sub, pw_err.
  - Registers the lower-half result [XLEN/2-1:0].
  - Registers the carry out of bit XLEN/2-1.
- Stage 2:
  - Computes the upper half.
  - Carry into bit XLEN/2 is the registered mid-carry only when pw[0]=1. Otherwise it is the lane-start carry-in.
  - Result and flags are registered; outputs are driven directly from stage-2 registers.
- Latency:
  - Operands accepted at edge k give out_valid=1 from edge k+1 when not stalled.
  - Throughput is one op per cycle with out_ready held high.
- Flow control:
  - s2_adv = s1_valid & (!s2_valid | out_ready).
  - in_ready = !s1_valid | s2_adv.
  - No combinational path from in_valid to out_valid.
  - in_ready depends on out_ready combinationally; this is a registered-slice style pipeline.
- Ordering: strictly in order, no drops, no duplicates. A stalled result holds result, pw_err and flags stable until out_ready.
- Lane arithmetic:
  - Subtract is lhs + ~rhs + 1 per lane. Carry-in of 1 is injected at every lane LSB when sub=1.
  - Carries never propagate across a lane boundary.
- Invalid pw (zero or more than one bit set):
  - Op still flows through the pipeline with normal latency and handshake.
  - result=0, pw_err=1.
- Simultaneous output drain and input accept with both stages full: legal. Both stages advance on the same edge.
- Reset mid-operation: all in-flight ops discarded immediately. out_valid drops asynchronously with reset.

Optional Feature:
- Macro: P_ADDSUB_PIPE_FLAGS_EN.
- Defined:
  - Adds output port out_flags, XLEN/2 bits, registered in stage 2.
  - Bit j is the carry out of lane j (add), or the borrow out of lane j (sub; borrow = inverted carry).
  - Lanes are numbered from LSB. Bits at or above the lane count are 0.
  - Held stable under stall; 0 on reset and when pw_err=1.
- Undefined: port absent, no flag logic.

Test Plan:
- XLEN=32, pw=00001, sub=0, lhs=0x0000FFFF, rhs=0x00000001, out_ready=1 -> result=0x00010000 one cycle after acceptance (mid-carry crossing); out_flags=0.
- pw=00100, sub=1, lhs=0x00000000, rhs=0x01010101 -> result=0xFFFFFFFF; out_flags[3:0]=0xF, out_flags[15:4]=0.
- pw=10000, sub=0, lhs=0xFFFFFFFF, rhs=0x55555555 -> result=0x00000000 (every 2-bit lane 3+1 wraps); out_flags=0xFFFF.
- Three ops issued back-to-back (0x1+0x2, 0x3+0x4, 0x5+0x6; pw=00001), out_ready=0 for 5 cycles then 1:
  - in_ready=0 once 2 ops are held.
  - Third op waits, then outputs 0x3, 0x7, 0xB appear in order on consecutive cycles.
  - result stays stable while stalled.
- pw=00011, lhs=0x12345678, rhs=0x1 -> result=0, pw_err=1, normal latency; next op with pw=00001 has pw_err=0.
- Two ops in flight, reset pulsed 1 cycle:
  - out_valid=0 immediately.
  - No stale result appears after reset.
  - in_ready=1 in the first cycle after deassertion.
- XLEN=64, pw=000001, lhs=0x00000000FFFFFFFF, rhs=0x1 -> result=0x0000000100000000.
